// File: rtl/axis_master_pkt_gen.sv
// axis_master_pkt_gen: AXI-Stream master emitting fixed-length counted packets with gaps and optional tvalid throttling
// Ports:
//   m_axis_aclk / m_axis_areset : clock, asynchronous active-high reset
//   start                       : one-cycle run command, honoured only while idle
//   busy                        : high while a run is in progress
//   pkt_count                   : packets completed since the last start
//   m_axis_*                    : AXI-Stream master, tdata = {pkt_idx, beat_idx}
module axis_master_pkt_gen #(
  parameter int PKT_LEN    = 16,
  parameter int GAP_CYCLES = 4,
  parameter int NUM_PKTS   = 4,
  parameter int FLOW_SIM   = 1
) (
  input  logic        m_axis_aclk,
  input  logic        m_axis_areset,
  input  logic        start,
  output logic        busy,
  output logic [15:0] pkt_count,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tstrb,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t      state_q, state_d;
  logic [15:0] beat_q, beat_d, pkt_idx_q, pkt_idx_d, pkt_count_q, pkt_count_d;
  logic [7:0]  gap_q, gap_d;
  logic [5:0]  lfsr_q, lfsr_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, hs;
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    pkt_idx_d   = pkt_idx_q;
    pkt_count_d = pkt_count_q;
    gap_d       = gap_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    hs          = tvalid_q & m_axis_tready;
    lfsr_d      = {lfsr_q[4:0], ~(lfsr_q[5] ^ lfsr_q[4])};
    case (state_q)
      IDLE: if (start) begin
        pkt_idx_d   = '0;
        pkt_count_d = '0;
        beat_d      = '0;
        state_d     = SEND;
      end
      SEND: if (hs) begin
        if (tlast_q) begin
          beat_d      = '0;
          gap_d       = '0;
          pkt_idx_d   = pkt_idx_q + 16'd1;
          pkt_count_d = pkt_count_q + 16'd1;
          if (NUM_PKTS != 0 && pkt_count_d == 16'(NUM_PKTS)) state_d = IDLE;
          else if (GAP_CYCLES != 0) state_d = GAP;
        end else beat_d = beat_q + 16'd1;
      end
      GAP: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == 8'(GAP_CYCLES - 1)) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
    // A beat still waiting for tready is frozen; otherwise load the next beat
    // for the coming cycle, so gaps end and back-to-back packets flow without
    // a bubble.
    if (!tvalid_q || hs) begin
      tvalid_d = (state_d == SEND) && (FLOW_SIM == 0 || lfsr_q[5]);
      tlast_d  = tvalid_d && beat_d == 16'(PKT_LEN - 1);
      tdata_d  = tvalid_d ? {pkt_idx_d, beat_d} : tdata_q;
    end
  end
  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      pkt_idx_q   <= '0;
      pkt_count_q <= '0;
      gap_q       <= '0;
      lfsr_q      <= 6'b000101;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      pkt_idx_q   <= pkt_idx_d;
      pkt_count_q <= pkt_count_d;
      gap_q       <= gap_d;
      lfsr_q      <= lfsr_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end
  assign busy          = state_q != IDLE;
  assign pkt_count     = pkt_count_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tstrb  = 4'hF;
  assign m_axis_tkeep  = 4'hF;
endmodule

// File: tb/tb_axis_master_pkt_gen.sv
// tb_axis_master_pkt_gen: directed and randomised checks of axis_master_pkt_gen against a packet-sequence model
module tb_axis_master_pkt_gen;
  logic        clk = 1'b0;
  logic        rst [3];
  logic        start [3];
  logic        ready [3];
  logic        busy [3];
  logic        tvalid [3];
  logic        tlast [3];
  logic [15:0] pcnt [3];
  logic [31:0] tdata [3];
  logic [3:0]  tstrb [3];
  logic [3:0]  tkeep [3];
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  axis_master_pkt_gen #(.PKT_LEN(16), .GAP_CYCLES(4), .NUM_PKTS(2), .FLOW_SIM(0)) u0 (
    .m_axis_aclk(clk), .m_axis_areset(rst[0]), .start(start[0]), .busy(busy[0]),
    .pkt_count(pcnt[0]), .m_axis_tdata(tdata[0]), .m_axis_tstrb(tstrb[0]),
    .m_axis_tkeep(tkeep[0]), .m_axis_tvalid(tvalid[0]), .m_axis_tready(ready[0]),
    .m_axis_tlast(tlast[0]));
  axis_master_pkt_gen #(.PKT_LEN(16), .GAP_CYCLES(4), .NUM_PKTS(3), .FLOW_SIM(1)) u1 (
    .m_axis_aclk(clk), .m_axis_areset(rst[1]), .start(start[1]), .busy(busy[1]),
    .pkt_count(pcnt[1]), .m_axis_tdata(tdata[1]), .m_axis_tstrb(tstrb[1]),
    .m_axis_tkeep(tkeep[1]), .m_axis_tvalid(tvalid[1]), .m_axis_tready(ready[1]),
    .m_axis_tlast(tlast[1]));
  axis_master_pkt_gen #(.PKT_LEN(1), .GAP_CYCLES(0), .NUM_PKTS(4), .FLOW_SIM(0)) u2 (
    .m_axis_aclk(clk), .m_axis_areset(rst[2]), .start(start[2]), .busy(busy[2]),
    .pkt_count(pcnt[2]), .m_axis_tdata(tdata[2]), .m_axis_tstrb(tstrb[2]),
    .m_axis_tkeep(tkeep[2]), .m_axis_tvalid(tvalid[2]), .m_axis_tready(ready[2]),
    .m_axis_tlast(tlast[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One start command on instance k; every accepted beat is compared against
  // the ideal sequence {p, b} for p < np, b < pl. With tight set, beat spacing
  // must be one cycle inside a packet and gp+1 cycles across packets.
  task automatic run(input int k, input int np, input int pl, input int gp,
                     input bit tight, input bit rnd, input bit poke);
    logic [31:0] got [$];
    logic        gl [$];
    int          cyc [$];
    int          c = 0;
    bit          pv = 0, pr = 0, pla = 0;
    logic [31:0] pd = '0;
    ready[k] = 1'b1;
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    chk($sformatf("busy_after_start%0d", k), 32'(busy[k]), 32'd1);
    while (busy[k] && c < 2000) begin
      if (pv && !pr) begin
        chk($sformatf("hold_valid%0d", k), 32'(tvalid[k]), 32'd1);
        chk($sformatf("hold_data%0d", k), tdata[k], pd);
        chk($sformatf("hold_last%0d", k), 32'(tlast[k]), 32'(pla));
      end
      ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) start[k] = (c == 5 || c == 17 || c == 18);
      pv = tvalid[k]; pr = ready[k]; pd = tdata[k]; pla = tlast[k];
      if (pv && pr) begin
        got.push_back(pd);
        gl.push_back(pla);
        cyc.push_back(c);
      end
      @(posedge clk); #1;
      c++;
    end
    start[k] = 1'b0;
    ready[k] = 1'b1;
    chk($sformatf("run_done%0d", k), 32'(busy[k]), 32'd0);
    chk($sformatf("beat_count%0d", k), 32'(got.size()), 32'(np * pl));
    for (int i = 0; i < got.size() && i < np * pl; i++) begin
      chk($sformatf("tdata%0d[%0d]", k, i), got[i], {16'(i / pl), 16'(i % pl)});
      chk($sformatf("tlast%0d[%0d]", k, i), 32'(gl[i]), 32'(i % pl == pl - 1));
      if (tight && i > 0)
        chk($sformatf("spacing%0d[%0d]", k, i), 32'(cyc[i] - cyc[i-1]),
            32'((i % pl == 0) ? gp + 1 : 1));
    end
    chk($sformatf("pkt_count%0d", k), 32'(pcnt[k]), 32'(np));
  endtask

  initial begin
    bit found = 0;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; ready[i] = 1'b1;
    end
    #1;
    chk("rst_tvalid", 32'(tvalid[0]), 32'd0);
    chk("rst_tlast", 32'(tlast[0]), 32'd0);
    chk("rst_tdata", tdata[0], 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_pkt_count", 32'(pcnt[0]), 32'd0);
    chk("tstrb", 32'(tstrb[0]), 32'hF);
    chk("tkeep", 32'(tkeep[0]), 32'hF);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(posedge clk); #1;
    run(0, 2, 16, 4, 1, 0, 0);
    run(0, 2, 16, 4, 1, 0, 1);
    run(1, 3, 16, 4, 0, 1, 0);
    run(2, 4, 1, 0, 1, 0, 0);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (tvalid[0] && tdata[0] == 32'h7) begin
        found = 1;
        ready[0] = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("beat7_seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    chk("beat7_held_valid", 32'(tvalid[0]), 32'd1);
    chk("beat7_held_data", tdata[0], 32'h7);
    #2 rst[0] = 1'b1;
    #1;
    chk("midrst_tvalid", 32'(tvalid[0]), 32'd0);
    chk("midrst_tlast", 32'(tlast[0]), 32'd0);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_pkt_count", 32'(pcnt[0]), 32'd0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    ready[0] = 1'b1;
    @(posedge clk); #1;
    run(0, 2, 16, 4, 1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_master_pkt_gen.md
Name: axis_master_pkt_gen

Overview:
- AXI-Stream master packet generator.
- Sits directly upstream of the slave memory capture stage and drives its s_axis_* inputs.
- Emits a programmable number of fixed-length packets with a deterministic data pattern, idle gaps between packets, and optional pseudo-random tvalid throttling for flow-control simulation.
- Fully honours tready backpressure.

Parameters:
- PKT_LEN, 16: beats per packet. Legal range 1..65535.
- GAP_CYCLES, 4: idle cycles between the tlast handshake and the first beat of the next packet. Legal range 0..255.
- NUM_PKTS, 4: packets per start command. 0 means run until reset.
- FLOW_SIM, 1: 1 gates new-beat tvalid assertion with an LFSR; 0 means tvalid is asserted whenever data is available.

Ports:
- m_axis_aclk  in  1  clock.
- m_axis_areset  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle command pulse; sampled only in IDLE.
- busy  out  1  high whenever the state is not IDLE.
- pkt_count  out  16  number of completed packets since the last start; wraps at 65535.
- m_axis_tdata  out  32  beat payload.
- m_axis_tstrb  out  4  constant 4'hF.
- m_axis_tkeep  out  4  constant 4'hF.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on the final beat of each packet.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - tvalid=0, tlast=0, tdata=0, busy=0, pkt_count=0.
  - Beat and packet counters and gap counter cleared; LFSR seeded to 6'b000101.
  - Outputs change immediately on assertion, independent of clock.
  - Reset mid-packet abandons the packet; no tlast is emitted.
- Handshake:
  - A beat transfers on any rising edge where tvalid=1 and tready=1.
  - Once tvalid is asserted it stays high, and tdata/tlast stay stable, until that handshake.
  - tvalid never depends combinationally on tready.
  - All outputs are registered.
- Data pattern: tdata = {pkt_idx[15:0], beat_idx[15:0]}.
  - pkt_idx counts packets within the current run, starting at 0.
  - beat_idx runs 0..PKT_LEN-1.
  - tlast=1 exactly when beat_idx == PKT_LEN-1.
- FSM states: IDLE, SEND, GAP.
  - IDLE: on start=1, clear pkt_idx and pkt_count, go to SEND. tvalid is not asserted in the start cycle; first tvalid is at the earliest one cycle later (subject to FLOW_SIM).
  - SEND, handshake with tlast=0: increment beat_idx; the next beat presents the following cycle or later.
  - SEND, handshake with tlast=1:
    - Increment pkt_count and pkt_idx; reset beat_idx to 0.
    - If NUM_PKTS≠0 and the completed count equals NUM_PKTS, go to IDLE.
    - Else if GAP_CYCLES=0, stay in SEND (back-to-back; next beat may be valid the very next cycle).
    - Else go to GAP.
  - GAP: tvalid=0. Count exactly GAP_CYCLES cycles, then go to SEND.
  - start while busy is ignored.
- FLOW_SIM=1:
  - 6-bit LFSR: feedback lfsr[0] <= lfsr[5]^lfsr[4]^1, shift left. It advances every clock outside reset.
  - In SEND with tvalid=0, tvalid rises only on a cycle where lfsr[5]=1.
  - A held (not yet accepted) tvalid is never dropped.
- FLOW_SIM=0: in SEND, tvalid=1 whenever a beat is pending. This gives 1 beat/cycle under continuous tready.
- Wrap rules:
  - pkt_idx and pkt_count are 16 bits and wrap to 0 after 65535.
  - beat_idx width is 16 bits.
- Simultaneous events: reset dominates all. start in the same cycle as the final tlast handshake is ignored, because the state is not IDLE.

Test Plan:
- FLOW_SIM=0, PKT_LEN=16, GAP_CYCLES=4, NUM_PKTS=2, tready=1, start pulse:
  - Beats 0x00000000..0x0000000F with tlast on 0x0000000F.
  - Exactly 4 idle cycles, then 0x00010000..0x0001000F.
  - busy falls after the second tlast; pkt_count=2.
- Random tready (≈50%), FLOW_SIM=1, NUM_PKTS=3:
  - Checker confirms tdata/tlast stable and tvalid never drops while tready=0.
  - Capture of 48 beats matches the pattern with no loss or duplication.
- PKT_LEN=1, GAP_CYCLES=0, FLOW_SIM=0, NUM_PKTS=4, tready=1:
  - tlast=1 on every beat; tdata 0x00000000, 0x00010000, 0x00020000, 0x00030000 on consecutive cycles.
- Reset asserted on beat 7 of packet 0 while tready=0:
  - tvalid/tlast/busy go 0 before the next edge; pkt_count=0.
  - A new start restarts at tdata=0x00000000.
- start pulsed during SEND and during GAP: no effect on sequence or counters.
- Connected to the downstream slave memory stage, FLOW_SIM=1 both sides, PKT_LEN=16: slave memory words 0..15 equal the final packet's beats.
